// File: rtl/farm_arb_pkg.sv
// Shared definitions for the farm-road lane arbiter: FSM state encoding
// and default sizing parameters.
package farm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALL  = 2'd1,
        SERVE = 2'd2,
        CLEAR = 2'd3
    } arb_state_t;

    localparam int unsigned N_LANE_DEF   = 4;
    localparam int unsigned DEB_CYC_DEF  = 3;
    localparam int unsigned MAX_WAIT_DEF = 100;

endpackage

// File: rtl/farm_lane_arbiter_sensor_debounce.sv
// Single-bit vehicle sensor conditioner: 2-FF synchronizer followed by a
// debounce counter. The detected state only flips after the synced input
// has disagreed with it for DEB_CYC consecutive cycles.
module sensor_debounce
    import farm_arb_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sens_raw_i,
    output logic det_o
);

    localparam int unsigned CW = $clog2(DEB_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          det_q, det_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count cycles of disagreement; flip on the edge the count would hit DEB_CYC.
    always_comb begin
        cnt_d = '0;
        det_d = det_q;
        if (sync2_q != det_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                det_d = ~det_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer, counter and detected-state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            det_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sens_raw_i;
            sync2_q <= sync1_q;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
        end
    end

    assign det_o = det_q;

endmodule

// File: rtl/farm_lane_arbiter.sv
// Farm-road lane arbiter: debounces N_LANE lane sensors, latches pending
// calls, requests the farm-road green phase and grants exactly one lane per
// phase in round-robin order. The request is held only while the granted
// lane stays occupied so the light controller can end the phase early.
// Optional starvation alarm and override: define FARM_STARVE_ALARM_EN.
module farm_lane_arbiter
    import farm_arb_pkg::*;
#(
    parameter int unsigned N_LANE   = N_LANE_DEF,
    parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_LANE-1:0] sens_raw,
    input  logic              fg,
    input  logic              fy,
    output logic              c,
    output logic [N_LANE-1:0] gnt,
    output logic [N_LANE-1:0] pend,
    output logic [N_LANE-1:0] starve
);

    localparam int unsigned IW = $clog2(N_LANE);

    if (N_LANE < 2 || N_LANE > 8) begin : g_bad_nlane
        $error("farm_lane_arbiter: N_LANE must be 2..8");
    end
    if (DEB_CYC < 1 || DEB_CYC > 15) begin : g_bad_deb
        $error("farm_lane_arbiter: DEB_CYC must be 1..15");
    end
    if (MAX_WAIT < 1) begin : g_bad_wait
        $error("farm_lane_arbiter: MAX_WAIT must be nonzero");
    end

    arb_state_t        state_q, state_d;
    logic [N_LANE-1:0] det;
    logic [N_LANE-1:0] pend_q, pend_d;
    logic [N_LANE-1:0] clr_mask;
    logic [N_LANE-1:0] win_oh;
    logic [N_LANE-1:0] starve_w;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [IW-1:0]     next_win;
    logic              rr_found;
    int unsigned       rr_idx;

    for (genvar g = 0; g < N_LANE; g++) begin : g_deb
        sensor_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk        (clk),
            .rst_n      (rst_n),
            .sens_raw_i (sens_raw[g]),
            .det_o      (det[g])
        );
    end

    // One-hot decode of the latched winner.
    always_comb begin
        win_oh        = '0;
        win_oh[win_q] = 1'b1;
    end

`ifdef FARM_STARVE_ALARM_EN
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wcnt_q [N_LANE];
    logic [WW-1:0] wcnt_d [N_LANE];

    // Per-lane wait counters: cleared when idle, saturating while pending and not granted.
    always_comb begin
        for (int unsigned i = 0; i < N_LANE; i++) begin
            wcnt_d[i] = wcnt_q[i];
            if (!pend_q[i]) begin
                wcnt_d[i] = '0;
            end else if (!(state_q == SERVE && win_oh[i]) && wcnt_q[i] < WW'(MAX_WAIT)) begin
                wcnt_d[i] = wcnt_q[i] + WW'(1);
            end
            starve_w[i] = (wcnt_q[i] >= WW'(MAX_WAIT));
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_LANE; i++) wcnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_LANE; i++) wcnt_q[i] <= wcnt_d[i];
        end
    end
`else
    assign starve_w = '0;
`endif

    // Winner selection: first pending lane at or after ptr, cyclic; a starving
    // lane (lowest index) overrides when the alarm feature is built in.
    always_comb begin
        next_win = ptr_q;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int unsigned i = 0; i < N_LANE; i++) begin
            rr_idx = 32'(ptr_q) + i;
            if (rr_idx >= N_LANE) rr_idx = rr_idx - N_LANE;
            if (!rr_found && pend_q[rr_idx]) begin
                next_win = IW'(rr_idx);
                rr_found = 1'b1;
            end
        end
`ifdef FARM_STARVE_ALARM_EN
        for (int i = int'(N_LANE) - 1; i >= 0; i--) begin
            if (starve_w[i] && pend_q[i]) next_win = IW'(i);
        end
`endif
    end

    // Next-state and Moore output decode; c in SERVE follows the winner's sensor.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        c        = 1'b0;
        gnt      = '0;
        clr_mask = '0;
        case (state_q)
            IDLE: begin
                if (|pend_q) state_d = CALL;
            end
            CALL: begin
                c = 1'b1;
                if (fg) begin
                    win_d   = next_win;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                gnt = win_oh;
                c   = |(det & win_oh);
                if (fy) begin
                    state_d  = CLEAR;
                    clr_mask = win_oh;
                    ptr_d    = (win_q == IW'(N_LANE - 1)) ? '0 : win_q + IW'(1);
                end
            end
            CLEAR: begin
                if (!fy) state_d = (|pend_q) ? CALL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending calls: set while detected, cleared for the winner at end of SERVE (clear wins).
    always_comb begin
        pend_d = (pend_q | det) & ~clr_mask;
    end

    // State, pointer, winner and pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            pend_q  <= pend_d;
        end
    end

    assign pend   = pend_q;
    assign starve = starve_w;

endmodule
